// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART word loader
//   loader_state_t   : loader FSM states (COLLECT, WRITE, FULL)
//   rx_state_t       : serial receiver FSM states
//   DEFAULT_BAUD_DIV : default clocks per UART bit
//   cnt_width()      : counter width helper, never narrower than 1 bit
package uart_loader_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        FULL    = 2'd2
    } loader_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    localparam int DEFAULT_BAUD_DIV = 434;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_loader_rx.sv
// rtl/uart_loader_rx.sv - 8N1 UART receiver with hold-until-consumed byte output
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   RX        : serial input, idle high
//   byte_data : last received byte (valid when valid=1)
//   valid     : held high from a good stop bit until consume
//   consume   : clears valid on the next edge
module uart_loader_rx
    import uart_loader_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] byte_data,
    output logic       valid,
    input  logic       consume
);

    localparam int BW = cnt_width(BAUD_DIV);
    localparam logic [BW-1:0] BIT_RELOAD  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_RELOAD = BW'(BAUD_DIV / 2 - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            tick;

    // Two-flop synchroniser; reset to the idle line level so no false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        tick    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                tick = (baud_cnt == '0);
                // A start bit that is high again at mid-bit was a glitch.
                if (tick) state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                tick = (baud_cnt == '0);
                if (tick && bit_cnt == 3'd7) state_n = RX_STOP;
            end
            RX_STOP: begin
                tick = (baud_cnt == '0);
                // A low stop bit means a framing error or break: wait for the
                // line to return high before hunting for the next start bit.
                if (tick) state_n = rx_s ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: begin
                if (rx_s) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            byte_data <= 8'd0;
            valid     <= 1'b0;
        end else begin
            if (consume) valid <= 1'b0;

            case (state)
                RX_IDLE:                    baud_cnt <= HALF_RELOAD;
                RX_START, RX_DATA, RX_STOP: baud_cnt <= tick ? BIT_RELOAD : baud_cnt - 1'b1;
                default:                    baud_cnt <= baud_cnt;
            endcase

            if (tick) begin
                case (state)
                    RX_START: bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_STOP: begin
                        // A new byte takes precedence over a same-cycle consume.
                        if (rx_s) begin
                            byte_data <= shreg;
                            valid     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - loads UART bytes into words and writes them to sequential addresses
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   en       : load enable; low holds and clears the loader
//   RX       : UART 8N1 serial input
//   addr     : word address being written
//   data     : last assembled word, stable between completions
//   we       : one-cycle write strobe
//   full     : last address has been written
//   timeout  : sticky, a partial word was discarded after idle
//   checksum : running byte sum, present only with LOADER_CHECKSUM_EN
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_W      = 13,
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    RX,
    output logic [ADDR_W-1:0]       addr,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    we,
    output logic                    full,
    output logic                    timeout
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]              checksum
`endif
);

    localparam int W      = 8 * DATA_BYTES;
    localparam int CNT_W  = cnt_width(DATA_BYTES);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(DATA_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_consume;
    logic              accept;
    logic              word_done;
    logic [W-1:0]      word_next;
    logic [CNT_W-1:0]  byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    loader_state_t     state;
    loader_state_t     state_n;

    uart_loader_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .byte_data (rx_byte),
        .valid     (rx_valid),
        .consume   (rx_consume)
    );

    assign accept    = rx_valid && en && (state == COLLECT);
    assign word_done = accept && (byte_cnt == LAST_BYTE);
    // The receiver holds its byte through WRITE; everywhere else a pending
    // byte is taken (accepted in COLLECT, dropped in FULL or while disabled).
    assign rx_consume = rx_valid && !(en && (state == WRITE));
    assign we         = en && (state == WRITE);

    // The assembly register holds only the bytes already received; the
    // incoming byte is spliced in combinationally to form the next word.
    generate
        if (DATA_BYTES == 1) begin : g_single
            assign word_next = rx_byte;
        end else begin : g_asm
            logic [W-9:0] asm_q;
            if (MSB_FIRST != 0) begin : g_msb
                assign word_next = {asm_q, rx_byte};
            end else begin : g_lsb
                assign word_next = {rx_byte, asm_q};
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    asm_q <= '0;
                end else if (accept) begin
                    asm_q <= (MSB_FIRST != 0) ? word_next[W-9:0] : word_next[W-1:8];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = COLLECT;
        end else begin
            case (state)
                COLLECT: if (word_done) state_n = WRITE;
                WRITE:   state_n = (addr == LAST_ADDR) ? FULL : COLLECT;
                FULL:    state_n = FULL;
                default: state_n = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            data     <= '0;
            full     <= 1'b0;
            timeout  <= 1'b0;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else if (!en) begin
            addr     <= '0;
            full     <= 1'b0;
            timeout  <= 1'b0;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            // A byte in the same cycle as idle expiry wins: it is accepted
            // and the idle counter restarts.
            if (accept) begin
                idle_cnt <= '0;
                if (word_done) begin
                    byte_cnt <= '0;
                    data     <= word_next;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end else if (byte_cnt != '0) begin
                if (idle_cnt == IDLE_LAST) begin
                    byte_cnt <= '0;
                    timeout  <= 1'b1;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            if (state == WRITE) begin
                if (addr == LAST_ADDR) begin
                    full <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= 8'd0;
        end else if (!en) begin
            checksum <= 8'd0;
        end else if (accept) begin
            checksum <= checksum + rx_byte;
        end
    end
`endif

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - randomized self-checking bench for uart_loader (two DUT configurations)
module tb_uart_loader;

    localparam int BAUD = 8;
    localparam int TO   = 300;

    typedef struct packed {
        logic [12:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        rx  = 1'b1;

    logic [1:0]  addr_a;
    logic [31:0] data_a;
    logic        we_a, full_a, timeout_a;
    logic [12:0] addr_b;
    logic [31:0] data_b;
    logic        we_b, full_b, timeout_b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  cs_a, cs_b;
`endif

    int checks   = 0;
    int failures = 0;
    int we_cnt_a = 0;
    int we_cnt_b = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    int         m_cnt[2];
    logic [7:0] m_bytes[2][4];
    int         m_addr[2];
    bit         m_full[2];
    bit         m_to[2];
    logic [7:0] m_sum[2];
    int         max_addr[2] = '{3, 8191};

    always #5 clk = ~clk;

    uart_loader #(
        .DATA_BYTES(4), .ADDR_W(2), .BAUD_DIV(BAUD), .MSB_FIRST(1), .TIMEOUT_CYC(TO)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .RX(rx),
        .addr(addr_a), .data(data_a), .we(we_a), .full(full_a), .timeout(timeout_a)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs_a)
`endif
    );

    uart_loader #(
        .DATA_BYTES(4), .ADDR_W(13), .BAUD_DIV(BAUD), .MSB_FIRST(0), .TIMEOUT_CYC(TO)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .RX(rx),
        .addr(addr_b), .data(data_b), .we(we_b), .full(full_b), .timeout(timeout_b)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word as it must appear once four bytes have arrived, from byte order alone.
    function automatic logic [31:0] assemble(input int d);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) begin
            if (d == 0) w = w | (32'(m_bytes[d][i]) << (8 * (3 - i)));
            else        w = w | (32'(m_bytes[d][i]) << (8 * i));
        end
        return w;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!m_full[d]) begin
                m_bytes[d][m_cnt[d]] = b;
                m_cnt[d]++;
                m_sum[d] = m_sum[d] + b;
                if (m_cnt[d] == 4) begin
                    e.a = 13'(m_addr[d]);
                    e.d = assemble(d);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    m_cnt[d] = 0;
                    if (m_addr[d] == max_addr[d]) m_full[d] = 1'b1;
                    else                          m_addr[d]++;
                end
            end
        end
    endtask

    task automatic model_clear(input bit full_reset);
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_addr[d] = 0;
            m_full[d] = 1'b0;
            m_to[d]   = 1'b0;
            m_sum[d]  = 8'd0;
        end
        if (full_reset) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic model_idle_long();
        for (int d = 0; d < 2; d++) begin
            if (m_cnt[d] != 0) begin
                m_to[d]  = 1'b1;
                m_cnt[d] = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        if (good) model_byte(b);
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = good;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD + $urandom_range(0, 10)) @(negedge clk);
    endtask

    task automatic pulse_en_low();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        model_clear(1'b0);
        #1;
    endtask

    // Every cycle: a strobe must match the next expected write; otherwise
    // the data output must still show the last written word.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (we_a) begin
                we_cnt_a++;
                if (q0.size() == 0) begin
                    chk("we_a unexpected", 64'(we_a), 64'(0));
                end else begin
                    e = q0.pop_front();
                    chk("we_a addr", 64'(addr_a), 64'(e.a[1:0]));
                    chk("we_a data", 64'(data_a), 64'(e.d));
                    last_a = e.d;
                end
            end else begin
                chk("data_a hold", 64'(data_a), 64'(last_a));
            end
            if (we_b) begin
                we_cnt_b++;
                if (q1.size() == 0) begin
                    chk("we_b unexpected", 64'(we_b), 64'(0));
                end else begin
                    e = q1.pop_front();
                    chk("we_b addr", 64'(addr_b), 64'(e.a));
                    chk("we_b data", 64'(data_b), 64'(e.d));
                    last_b = e.d;
                end
            end else begin
                chk("data_b hold", 64'(data_b), 64'(last_b));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int wa;
        logic [7:0] b;
        model_clear(1'b1);

        repeat (4) @(negedge clk);
        chk("rst addr_a", 64'(addr_a), 64'(0));
        chk("rst data_a", 64'(data_a), 64'(0));
        chk("rst we_a", 64'(we_a), 64'(0));
        chk("rst full_a", 64'(full_a), 64'(0));
        chk("rst timeout_a", 64'(timeout_a), 64'(0));
        rst = 1'b0;
        en  = 1'b1;
        repeat (4) @(negedge clk);

        // First word in both byte orders
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        chk("msb word", 64'(data_a), 64'h0000_0000_DEAD_BEEF);
        chk("lsb word", 64'(data_b), 64'h0000_0000_EFBE_ADDE);
        chk("addr_a after 1", 64'(addr_a), 64'(1));
        chk("addr_b after 1", 64'(addr_b), 64'(1));
        chk("we_cnt_a 1", 64'(we_cnt_a), 64'(1));
        chk("we_cnt_b 1", 64'(we_cnt_b), 64'(1));

        // Fill the 4-word space of dut_a; fifth word must be ignored
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        chk("full_a set", 64'(full_a), 64'(1));
        chk("addr_a held", 64'(addr_a), 64'(3));
        chk("we_cnt_a 4", 64'(we_cnt_a), 64'(4));
        chk("addr_b 5", 64'(addr_b), 64'(5));
        chk("we_cnt_b 5", 64'(we_cnt_b), 64'(5));

        pulse_en_low();
        chk("en clr addr_a", 64'(addr_a), 64'(0));
        chk("en clr full_a", 64'(full_a), 64'(0));
        chk("en clr addr_b", 64'(addr_b), 64'(0));

        // Partial word abandoned by idle timeout
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (TO + 10) @(negedge clk);
        model_idle_long();
        chk("timeout_a", 64'(timeout_a), 64'(m_to[0]));
        chk("timeout_b", 64'(timeout_b), 64'(1));
        chk("no we on timeout", 64'(we_cnt_a), 64'(4));
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        chk("post-timeout msb", 64'(data_a), 64'h0102_0304);
        chk("post-timeout lsb", 64'(data_b), 64'h0403_0201);
        chk("timeout sticky", 64'(timeout_a), 64'(1));

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        rx = 1'b0;
        repeat (BAUD + 3) @(negedge clk);
        #3;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("arst addr_a", 64'(addr_a), 64'(0));
        chk("arst data_a", 64'(data_a), 64'(0));
        chk("arst timeout_a", 64'(timeout_a), 64'(0));
        chk("arst we_a", 64'(we_a), 64'(0));
        chk("arst full_a", 64'(full_a), 64'(0));
        chk("arst data_b", 64'(data_b), 64'(0));
        repeat (3) @(negedge clk);
        model_clear(1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        chk("post-rst word", 64'(data_a), 64'hAABB_CCDD);
        chk("post-rst addr", 64'(addr_a), 64'(1));

        // Bytes 01..08 then a framing error byte
        pulse_en_low();
        wa = we_cnt_a;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h09, 1'b0);
        chk("two words", 64'(we_cnt_a - wa), 64'(2));
        chk("second word", 64'(data_a), 64'h0506_0708);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum 24", 64'(cs_a), 64'h24);
        chk("checksum b", 64'(cs_b), 64'(m_sum[1]));
`endif

        // Randomised traffic with occasional bad stop bits
        pulse_en_low();
        for (int i = 0; i < 28; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, ($urandom_range(0, 7) != 0));
        end
        chk("rand addr_a", 64'(addr_a), 64'(m_addr[0]));
        chk("rand full_a", 64'(full_a), 64'(m_full[0]));
        chk("rand addr_b", 64'(addr_b), 64'(m_addr[1]));
        chk("rand timeout_a", 64'(timeout_a), 64'(m_to[0]));
`ifdef LOADER_CHECKSUM_EN
        chk("rand checksum a", 64'(cs_a), 64'(m_sum[0]));
        chk("rand checksum b", 64'(cs_b), 64'(m_sum[1]));
`endif
        chk("q0 drained", 64'(q0.size()), 64'(0));
        chk("q1 drained", 64'(q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
